// File: rtl/sar_search_ctrl_if.sv
// Comparator-side bundle for sar_search_ctrl: control handshake, trial/flag
// exchange with the external comparator, and search results.
interface sar_search_ctrl_if #(
    parameter int N = 8
);
    localparam int SW = $clog2(N + 1);

    logic          start;
    logic          abort;
    logic          cmp_L;
    logic          cmp_G;
    logic          cmp_E;
    logic [N-1:0]  trial;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;
    logic          exact_hit;
    logic [SW-1:0] steps;
    logic          err;

    modport master (
        input  start, abort, cmp_L, cmp_G, cmp_E,
        output trial, busy, done, result, exact_hit, steps, err
    );

    modport slave (
        output start, abort, cmp_L, cmp_G, cmp_E,
        input  trial, busy, done, result, exact_hit, steps, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation controller: drives trial values to an external
// comparator and binary-searches MSB->LSB to recover its A operand.
module sar_search_ctrl #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    sar_search_ctrl_if.master   bus
);
    localparam int SW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  trial_q, trial_d;
    logic [N-1:0]  result_q, result_d;
    logic [SW-1:0] steps_q, steps_d;
    logic [SW-1:0] k_q, k_d;
    logic          hit_q, hit_d;
    logic          err_q, err_d;
    logic [N-1:0]  cand;
    logic          one_hot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            k_q      <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            k_q      <= k_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        steps_d  = steps_q;
        k_d      = k_q;
        hit_d    = hit_q;
        err_d    = err_q;
        one_hot  = ({bus.cmp_L, bus.cmp_G, bus.cmp_E} == 3'b100) ||
                   ({bus.cmp_L, bus.cmp_G, bus.cmp_E} == 3'b010) ||
                   ({bus.cmp_L, bus.cmp_G, bus.cmp_E} == 3'b001);
        // L means the trial overshot A, so bit k of the candidate is dropped
        cand     = bus.cmp_L ? (trial_q & ~(N'(1) << k_q)) : trial_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    trial_d        = '0;
                    trial_d[N-1]   = 1'b1;
                    k_d            = SW'(N - 1);
                    steps_d        = '0;
                    hit_d          = 1'b0;
                    err_d          = 1'b0;
                    state_d        = SEARCH;
                end
            end
            SEARCH: begin
                if (bus.abort) begin
                    trial_d = '0;
                    state_d = IDLE;
                end else begin
                    steps_d = steps_q + 1'b1;
                    if (!one_hot) begin
                        err_d    = 1'b1;
                        result_d = trial_q;
                        trial_d  = '0;
                        state_d  = DONE;
                    end else if (bus.cmp_E) begin
                        hit_d    = 1'b1;
                        result_d = trial_q;
                        trial_d  = '0;
                        state_d  = DONE;
                    end else if (k_q == '0) begin
                        result_d = cand;
                        trial_d  = '0;
                        state_d  = DONE;
                    end else begin
                        trial_d  = cand | (N'(1) << (k_q - 1'b1));
                        k_d      = k_q - 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.trial     = trial_q;
    assign bus.busy      = (state_q == SEARCH);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.exact_hit = hit_q;
    assign bus.steps     = steps_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl with a behavioural comparator on trial.
module tb_sar_search_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_val;
    logic       force_bad;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    sar_search_ctrl_if #(.N(8)) bus ();

    sar_search_ctrl #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Forcing L=G=1 produces a non-one-hot flag set
    always_comb begin
        bus.cmp_L = force_bad | (a_val < bus.trial);
        bus.cmp_G = force_bad | (a_val > bus.trial);
        bus.cmp_E = !force_bad && (a_val == bus.trial);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        a_val = 8'h00;
        force_bad = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.trial, bus.result, bus.steps} !== 20'h0)
            $display("FAIL reset_values trial=%h result=%h steps=%0d expected 0/0/0",
                     bus.trial, bus.result, bus.steps);
        checks++;
        if ({bus.busy, bus.done, bus.exact_hit, bus.err} !== 4'b0000)
            $display("FAIL reset_flags busy/done/hit/err=%b expected 0000",
                     {bus.busy, bus.done, bus.exact_hit, bus.err});
        if ({bus.trial, bus.result, bus.steps} !== 20'h0) errors++;
        if ({bus.busy, bus.done, bus.exact_hit, bus.err} !== 4'b0000) errors++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_trial_sequence();
        logic [7:0] exp_tr [6] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4};
        a_val = 8'hA4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.trial !== exp_tr[i] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL seq_trial[%0d] trial=%h busy=%b done=%b expected %h/1/0",
                         i, bus.trial, bus.busy, bus.done, exp_tr[i]);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 8'hA4 || bus.steps !== 4'd6 ||
            bus.exact_hit !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL seq_done done=%b result=%h steps=%0d hit=%b err=%b expected 1/a4/6/1/0",
                     bus.done, bus.result, bus.steps, bus.exact_hit, bus.err);
        end
        tick();
    endtask

    task automatic run_search(input logic [7:0] a, input int exp_steps, input logic exp_hit);
        int n;
        a_val = a;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.trial !== 8'h80) begin
            errors++;
            $display("FAIL first_trial a=%h busy=%b trial=%h expected 1/80", a, bus.busy, bus.trial);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (n !== exp_steps) begin
            errors++;
            $display("FAIL latency a=%h edges=%0d expected %0d", a, n, exp_steps);
        end
        checks++;
        if (bus.result !== a || bus.steps !== 4'(exp_steps) || bus.exact_hit !== exp_hit ||
            bus.err !== 1'b0 || bus.trial !== 8'h00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL search_result a=%h result=%h steps=%0d hit=%b err=%b trial=%h busy=%b expected %h/%0d/%b/0/00/0",
                     a, bus.result, bus.steps, bus.exact_hit, bus.err, bus.trial, bus.busy,
                     a, exp_steps, exp_hit);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== a) begin
            errors++;
            $display("FAIL done_width a=%h done=%b busy=%b result=%h expected 0/0/%h",
                     a, bus.done, bus.busy, bus.result, a);
        end
    endtask

    task automatic test_search();
        run_search(8'h80, 1, 1'b1);
        run_search(8'h00, 8, 1'b0);
        run_search(8'hFF, 8, 1'b1);
        run_search(8'h5B, 8, 1'b1);
        run_search(8'h01, 8, 1'b1);
    endtask

    task automatic test_err();
        a_val = 8'h33;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.trial !== 8'h20 || bus.steps !== 4'd2) begin
            errors++;
            $display("FAIL err_pre trial=%h steps=%0d expected 20/2", bus.trial, bus.steps);
        end
        force_bad = 1'b1;
        tick();
        force_bad = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.steps !== 4'd3 ||
            bus.result !== 8'h20 || bus.exact_hit !== 1'b0 || bus.trial !== 8'h00) begin
            errors++;
            $display("FAIL err_done done=%b err=%b steps=%0d result=%h hit=%b trial=%h expected 1/1/3/20/0/00",
                     bus.done, bus.err, bus.steps, bus.result, bus.exact_hit, bus.trial);
        end
        tick();
    endtask

    task automatic test_abort();
        int seen = 0;
        a_val = 8'h33;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.trial !== 8'h00 ||
            bus.result !== 8'h20 || bus.steps !== 4'd3) begin
            errors++;
            $display("FAIL abort_state busy=%b done=%b trial=%h result=%h steps=%0d expected 0/0/00/20/3",
                     bus.busy, bus.done, bus.trial, bus.result, bus.steps);
        end
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done pulses=%0d expected 0", seen);
        end
    endtask

    task automatic test_reset_mid_search();
        int seen = 0;
        a_val = 8'h5B;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.trial, bus.result, bus.steps} !== 20'h0 ||
            {bus.busy, bus.done, bus.exact_hit, bus.err} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid trial=%h result=%h steps=%0d busy/done/hit/err=%b expected all 0",
                     bus.trial, bus.result, bus.steps, {bus.busy, bus.done, bus.exact_hit, bus.err});
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid_idle active_cycles=%0d expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        a_val = 8'h80;
        bus.start = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.trial !== 8'h80) begin
            errors++;
            $display("FAIL b2b_first busy=%b trial=%h expected 1/80", bus.busy, bus.trial);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.trial !== 8'h00) begin
            errors++;
            $display("FAIL b2b_done done=%b busy=%b trial=%h expected 1/0/00", bus.done, bus.busy, bus.trial);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.trial !== 8'h00) begin
            errors++;
            $display("FAIL b2b_idle done=%b busy=%b trial=%h expected 0/0/00", bus.done, bus.busy, bus.trial);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.trial !== 8'h80 || bus.steps !== 4'd0 || bus.exact_hit !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart busy=%b trial=%h steps=%0d hit=%b expected 1/80/0/0",
                     bus.busy, bus.trial, bus.steps, bus.exact_hit);
        end
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.result !== 8'h80 || bus.steps !== 4'd1) begin
            errors++;
            $display("FAIL b2b_second done=%b result=%h steps=%0d expected 1/80/1",
                     bus.done, bus.result, bus.steps);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_trial_sequence();
        test_search();
        test_err();
        test_abort();
        test_reset_mid_search();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
